// File: rtl/cordic_pkg.sv
// Shared constants and elaboration-time helpers for the CORDIC rotator.
package cordic_pkg;

  localparam int ANGLE_WIDTH = 20;
  localparam int Z_WIDTH     = 22;
  localparam int G           = 4;

  localparam int DEG_45  = 32'sd131072;
  localparam int DEG_90  = 32'sd262144;
  localparam int DEG_180 = 32'sd524288;

  // round(2^20 * atan(2^-i) / (2*pi)); entries past i=18 round to zero
  function automatic int atan_lut(input int i);
    case (i)
      0:       atan_lut = 32'sd131072;
      1:       atan_lut = 32'sd77376;
      2:       atan_lut = 32'sd40884;
      3:       atan_lut = 32'sd20753;
      4:       atan_lut = 32'sd10417;
      5:       atan_lut = 32'sd5213;
      6:       atan_lut = 32'sd2607;
      7:       atan_lut = 32'sd1304;
      8:       atan_lut = 32'sd652;
      9:       atan_lut = 32'sd326;
      10:      atan_lut = 32'sd163;
      11:      atan_lut = 32'sd81;
      12:      atan_lut = 32'sd41;
      13:      atan_lut = 32'sd20;
      14:      atan_lut = 32'sd10;
      15:      atan_lut = 32'sd5;
      16:      atan_lut = 32'sd3;
      17:      atan_lut = 32'sd1;
      18:      atan_lut = 32'sd1;
      default: atan_lut = 32'sd0;
    endcase
  endfunction

  // Gain-compensated start magnitude: round(A / 1.646760258) scaled by 2^g,
  // with A = 2^(dw-2)
  function automatic longint gain_k(input int dw, input int g);
    longint a;
    a = 64'sd1 <<< (dw - 2);
    gain_k = ((a * 64'sd607253 + 64'sd500000) / 64'sd1000000) <<< g;
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// One registered CORDIC micro-rotation driving the residual angle toward zero.
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int XW    = 18,
  parameter int SHIFT = 0,
  parameter int ATAN  = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [XW-1:0]      x_in,
  input  logic signed [XW-1:0]      y_in,
  input  logic signed [Z_WIDTH-1:0] z_in,
  output logic signed [XW-1:0]      x_out,
  output logic signed [XW-1:0]      y_out,
  output logic signed [Z_WIDTH-1:0] z_out
);

  localparam logic signed [Z_WIDTH-1:0] ATAN_C = Z_WIDTH'(ATAN);

  logic signed [XW-1:0] x_sh;
  logic signed [XW-1:0] y_sh;

  assign x_sh = x_in >>> SHIFT;
  assign y_sh = y_in >>> SHIFT;

  // Rotate by +atan when the residual is non-negative, otherwise by -atan
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_out <= '0;
      y_out <= '0;
      z_out <= '0;
    end else if (!z_in[Z_WIDTH-1]) begin
      x_out <= x_in - y_sh;
      y_out <= y_in + x_sh;
      z_out <= z_in - ATAN_C;
    end else begin
      x_out <= x_in + y_sh;
      y_out <= y_in - x_sh;
      z_out <= z_in + ATAN_C;
    end
  end

endmodule

// File: rtl/cordic_rotator.sv
// Free-running rotation-mode CORDIC: phase in, gain-compensated sin/cos out.
module cordic_rotator
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int STAGES     = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [ANGLE_WIDTH-1:0] target_angle,
  output logic signed [DATA_WIDTH-1:0]  sin_out,
  output logic signed [DATA_WIDTH-1:0]  cos_out
);

  localparam int XW = DATA_WIDTH + G + 2;

  localparam logic signed [XW-1:0]      K_POS    = XW'(gain_k(DATA_WIDTH, G));
  localparam logic signed [XW-1:0]      K_NEG    = -K_POS;
  localparam logic signed [Z_WIDTH-1:0] Z_POS90  = Z_WIDTH'(DEG_90);
  localparam logic signed [Z_WIDTH-1:0] Z_NEG90  = -Z_POS90;
  localparam logic signed [Z_WIDTH-1:0] Z_HALF   = Z_WIDTH'(DEG_180);
  localparam logic signed [XW:0]        ROUND_C  = (XW+1)'(1 << (G - 1));
  localparam logic signed [XW:0]        SAT_POS  = (XW+1)'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [XW:0]        SAT_NEG  = -SAT_POS;

  logic signed [Z_WIDTH-1:0] angle_ext;
  logic signed [Z_WIDTH-1:0] z_fold;
  logic signed [XW-1:0]      x_fold;

  logic signed [XW-1:0]      x_pre;
  logic signed [XW-1:0]      y_pre;
  logic signed [Z_WIDTH-1:0] z_pre;

  logic signed [XW-1:0]      x_pipe [0:STAGES];
  logic signed [XW-1:0]      y_pipe [0:STAGES];
  logic signed [Z_WIDTH-1:0] z_pipe [0:STAGES];

  logic unused_z;

  // Drop guard bits with round-half-up, then clamp to the symmetric output range
  function automatic logic signed [DATA_WIDTH-1:0] round_sat(input logic signed [XW-1:0] v);
    logic signed [XW:0] r;
    r = $signed({v[XW-1], v}) + ROUND_C;
    r = r >>> G;
    if (r > SAT_POS) begin
      round_sat = SAT_POS[DATA_WIDTH-1:0];
    end else if (r < SAT_NEG) begin
      round_sat = SAT_NEG[DATA_WIDTH-1:0];
    end else begin
      round_sat = r[DATA_WIDTH-1:0];
    end
  endfunction

  assign angle_ext = {{(Z_WIDTH-ANGLE_WIDTH){target_angle[ANGLE_WIDTH-1]}}, target_angle};

  // Fold the phase into [-90, +90] degrees; the far half-plane starts from -K
  always_comb begin
    z_fold = angle_ext;
    x_fold = K_POS;
    if (angle_ext > Z_POS90) begin
      z_fold = angle_ext - Z_HALF;
      x_fold = K_NEG;
    end else if (angle_ext < Z_NEG90) begin
      z_fold = angle_ext + Z_HALF;
      x_fold = K_NEG;
    end else begin
      z_fold = angle_ext;
      x_fold = K_POS;
    end
  end

  // Pre-rotation register feeding the micro-rotation chain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_pre <= '0;
      y_pre <= '0;
      z_pre <= '0;
    end else begin
      x_pre <= x_fold;
      y_pre <= '0;
      z_pre <= z_fold;
    end
  end

  assign x_pipe[0] = x_pre;
  assign y_pipe[0] = y_pre;
  assign z_pipe[0] = z_pre;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    cordic_stage #(
      .XW   (XW),
      .SHIFT(i),
      .ATAN (atan_lut(i))
    ) u_stage (
      .clk  (clk),
      .rst  (rst),
      .x_in (x_pipe[i]),
      .y_in (y_pipe[i]),
      .z_in (z_pipe[i]),
      .x_out(x_pipe[i+1]),
      .y_out(y_pipe[i+1]),
      .z_out(z_pipe[i+1])
    );
  end

  // The final residual angle is not needed downstream
  assign unused_z = ^z_pipe[STAGES];

  // Output register: y is the sine, x the cosine
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sin_out <= '0;
      cos_out <= '0;
    end else begin
      sin_out <= round_sat(y_pipe[STAGES]);
      cos_out <= round_sat(x_pipe[STAGES]);
    end
  end

endmodule

// File: tb/tb_cordic_rotator.sv
// Directed and ramp checks of cordic_rotator against hand values and ideal A*sin/cos.
module tb_cordic_rotator;

  localparam int DW   = 12;
  localparam int ST   = 12;
  localparam int LAT  = ST + 2;
  localparam int NRMP = 2000 + LAT;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic signed [19:0]    target_angle = '0;
  logic signed [DW-1:0]  sin_out;
  logic signed [DW-1:0]  cos_out;

  int checks = 0;
  int errors = 0;

  logic signed [19:0] hist [0:NRMP];
  int                 since_rel;

  always #5 clk = ~clk;

  cordic_rotator #(
    .DATA_WIDTH(DW),
    .STAGES    (ST)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .target_angle(target_angle),
    .sin_out     (sin_out),
    .cos_out     (cos_out)
  );

  task automatic check_value(input string tag, input int obs, input int exp, input int tol);
    int diff;
    checks++;
    diff = obs - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  function automatic int ideal(input int a, input bit want_sin);
    real ph;
    ph = 2.0 * 3.14159265358979 * real'(a) / 1048576.0;
    if (want_sin) return int'(1024.0 * $sin(ph));
    else          return int'(1024.0 * $cos(ph));
  endfunction

  function automatic logic signed [19:0] ramp_angle(input int k);
    int v;
    v = -524288 + 524 * k;
    return v[19:0];
  endfunction

  task automatic hold_angle(input string tag, input int a, input int s_exp, input int c_exp);
    @(posedge clk); #1;
    target_angle = a[19:0];
    repeat (LAT + 1) @(posedge clk);
    #1;
    check_value({tag, "_sin"}, sin_out, s_exp, 2);
    check_value({tag, "_cos"}, cos_out, c_exp, 2);
  endtask

  initial begin
    // reset state
    #7;
    check_value("rst_sin", sin_out, 0, 0);
    check_value("rst_cos", cos_out, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    hold_angle("a0",    0,       0,     1024);
    hold_angle("a45",   131072,  724,   724);
    check_value("a45_eq", sin_out, cos_out, 2);
    hold_angle("a90",   262144,  1024,  0);
    hold_angle("am90", -262144, -1024,  0);
    hold_angle("am180",-524288,  0,    -1024);
    hold_angle("a135",  393216,  724,  -724);

    // ramp with a mid-stream reset
    since_rel = 100;
    @(posedge clk); #1;
    hist[0] = ramp_angle(0);
    target_angle = hist[0];
    for (int k = 0; k < NRMP; k++) begin
      @(posedge clk);
      since_rel = rst ? since_rel + 1 : 0;
      #1;
      if (k >= LAT - 1) begin
        if (since_rel >= LAT) begin
          check_value("ramp_sin", sin_out, ideal(hist[k-LAT+1], 1'b1), 3);
          check_value("ramp_cos", cos_out, ideal(hist[k-LAT+1], 1'b0), 3);
        end else begin
          check_value("flush_sin", sin_out, 0, 0);
          check_value("flush_cos", cos_out, 0, 0);
        end
      end
      if (k == 1000) begin
        rst = 1'b0;
        #1;
        check_value("async_sin", sin_out, 0, 0);
        check_value("async_cos", cos_out, 0, 0);
      end
      if (k == 1003) begin
        @(negedge clk);
        rst = 1'b1;
      end
      hist[k+1] = ramp_angle(k + 1);
      target_angle = hist[k+1];
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cordic_rotator.md
# cordic_rotator

Fully pipelined CORDIC engine in rotation mode. It converts a 20-bit phase angle into signed sine and cosine samples at one result per clock. It sits in the video/audio processing datapath wherever a phase-to-sinusoid conversion is needed, such as colour-subcarrier generation or an NCO back-end. Gain compensation is built in, so outputs need no post-scaling.

## Interface
- DATA_WIDTH, 12: width of the signed sin/cos outputs.
- STAGES, 12: number of CORDIC micro-rotation stages; legal range 8..20.
- clk  in  1: single clock; all registers are on the rising edge.
- rst  in  1: asynchronous, active-low reset. Asserting it clears every pipeline register immediately. Release is synchronous to clk.
- target_angle  in  20 signed: phase, two's complement; full circle = 2^20.
  - 90° = 262144; 45° = 131072; -180° = -524288.
- sin_out  out  DATA_WIDTH signed: A·sin(angle).
- cos_out  out  DATA_WIDTH signed: A·cos(angle).
- A = 2^(DATA_WIDTH-2) (1024 for the defaults); format Q1.(DATA_WIDTH-2).

## Operation
- Stage P (pre-rotation, registered): folds the angle into [-90°, +90°].
  - If angle > +90°: z0 = angle − 2^19 (180°) and x0 = −K.
  - If angle < −90°: z0 = angle + 2^19 and x0 = −K.
  - Otherwise: z0 = angle and x0 = +K.
  - y0 = 0 in all cases.
  - K = round(A·2^G / 1.646760258) at internal scale, with G = 4 guard bits (622·16 for the defaults).
- Internal widths:
  - x and y: DATA_WIDTH+G+2 bits, signed; the extra 2 bits give overflow headroom.
  - z: 22 bits, signed.
- Stage i, for i = 0..STAGES-1, registered: d = sign(z), with z ≥ 0 taken as +1.
  - x' = x − d·(y>>>i)
  - y' = y + d·(x>>>i)
  - z' = z − d·atan_i
- atan table: atan_i = round(2^20·atan(2^-i)/(2π)).
  - atan_0 = 131072, atan_1 = 77376, atan_2 = 40884, and so on.
  - The table is a localparam array computed at elaboration; no runtime ROM.
- Output stage (registered):
  - Drop the G guard bits with round-half-up: add 2^(G-1), then arithmetic shift right by G.
  - Saturate to ±(2^(DATA_WIDTH-1)−1).
  - y maps to sin_out; x maps to cos_out.
- Accuracy: |error| ≤ 3 LSB versus ideal A·sin/cos over the full circle at the default parameters.
- Angle wrap: the input is modulo 2^20. Exactly −524288 (−180°) gives cos = −A and sin = 0.
- Reset values: sin_out = 0, cos_out = 0; all x/y/z pipeline registers = 0.

## Timing
- Latency: exactly STAGES+2 clock edges from target_angle sampled to the corresponding output (14 for the defaults).
  - Breakdown: 1 pre-rotation stage, STAGES rotation stages, 1 output stage.
- Throughput: one new angle accepted every cycle. There is no valid/ready handshake; the pipeline is free-running.
- Reset mid-stream: outputs go to 0 asynchronously on assertion.
  - After release, outputs stay 0 for STAGES+1 cycles.
  - The first valid result appears STAGES+2 cycles after the first post-reset sample.
- A change on target_angle never disturbs results already in flight.

## Structure
- Package cordic_pkg holds:
  - ANGLE_WIDTH = 20 and the angle constants DEG_45, DEG_90, DEG_180.
  - A function that returns atan_i for a given i.
  - The guard-bit constant G.
- Optional sub-module cordic_stage: one registered micro-rotation, parameterised by shift index and atan constant.
  - The top level instantiates it STAGES times in a generate loop, between the pre-rotation and output registers.

## Test plan
- Angle 0, held ≥14 cycles → sin_out 0±2, cos_out 1024±2.
- Angle 131072 (45°) → sin_out and cos_out both 724±2, and equal to each other within 2 LSB.
- Angle 262144 (90°) → sin_out 1024±2, cos_out 0±2. Angle −262144 (−90°) → sin_out −1024±2, cos_out 0±2.
- Angle −524288 (−180°) → sin_out 0±2, cos_out −1024±2. Angle 393216 (135°) → sin_out 724±2, cos_out −724±2.
- Ramp from −524288 in steps of +524 per cycle for 2000 cycles → every output matches the model 14 cycles later within 3 LSB, with no discontinuity at ±90° or ±180°.
- Assert rst low mid-ramp → outputs 0 immediately.
  - After release: 0 for 13 cycles, then correct values from the 14th cycle.
